// File: rtl/text_buffer_ctrl.sv
// Text-buffer controller: working text array with cursor, wrap/newline/backspace,
// multi-cycle scroll and clear, and a shadow copy committed only at frame start.

module text_buffer_row #(
  parameter int          ROW_SIZE   = 10,
  parameter logic [7:0]  CODE_BLANK = 8'd0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr,
  input  logic [3:0]               i_col,
  input  logic [7:0]               i_code,
  input  logic [3:0]               i_cnt,
  input  logic                     i_load,
  input  logic [ROW_SIZE-1:0][7:0] i_load_cells,
  input  logic [3:0]               i_load_cnt,
  input  logic                     i_blank,
  output logic [ROW_SIZE-1:0][7:0] o_cells,
  output logic [3:0]               o_cnt
);
  // Blank wins over load, load wins over a cell write; only one is ever active.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_cells <= {ROW_SIZE{CODE_BLANK}};
      o_cnt   <= 4'd0;
    end else if (i_blank) begin
      o_cells <= {ROW_SIZE{CODE_BLANK}};
      o_cnt   <= 4'd0;
    end else if (i_load) begin
      o_cells <= i_load_cells;
      o_cnt   <= i_load_cnt;
    end else if (i_wr) begin
      o_cells[i_col] <= i_code;
      o_cnt          <= i_cnt;
    end
  end
endmodule

module text_buffer_ctrl #(
  parameter int         ROW_CNT    = 3,
  parameter int         ROW_SIZE   = 10,
  parameter logic [7:0] CODE_BLANK = 8'd0,
  parameter logic [7:0] CODE_NL    = 8'd253,
  parameter logic [7:0] CODE_BS    = 8'd254,
  parameter logic [7:0] CODE_CLR   = 8'd255
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst,
  input  logic                                   i_valid,
  output logic                                   o_ready,
  input  logic [7:0]                             i_code,
  input  logic                                   i_frame_start,
  output logic [ROW_CNT-1:0][3:0]                o_letter_cnt,
  output logic [ROW_CNT-1:0][ROW_SIZE-1:0][7:0]  o_letters,
  output logic [1:0]                             o_cursor_row,
  output logic [3:0]                             o_cursor_col,
  output logic                                   o_dirty
);
  localparam int         SW        = (ROW_CNT > 1) ? $clog2(ROW_CNT) : 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(ROW_CNT-1);
  localparam logic [1:0] LAST_ROW  = 2'(ROW_CNT-1);
  localparam logic [3:0] LAST_COL  = 4'(ROW_SIZE-1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SCROLL = 2'd1;
  localparam logic [1:0] S_CLEAR  = 2'd2;

  logic [1:0]                            state, nxt_state;
  logic [SW-1:0]                         step;
  logic [1:0]                            row, nxt_row, row_m1;
  logic [3:0]                            col, nxt_col, col_m1, prev_cnt;
  logic [ROW_CNT-1:0][ROW_SIZE-1:0][7:0] work;
  logic [ROW_CNT-1:0][3:0]               cnt_arr;

  logic       accept, commit, set_dirty;
  logic       tgt_en;
  logic [1:0] tgt_row;
  logic [3:0] tgt_col, tgt_cnt;
  logic [7:0] tgt_code;

  assign o_ready      = (state == S_IDLE);
  assign accept       = i_valid & o_ready;
  assign commit       = i_frame_start & o_ready & o_dirty;
  assign o_cursor_row = row;
  assign o_cursor_col = col;
  assign row_m1       = row - 2'd1;
  assign col_m1       = col - 4'd1;
  assign prev_cnt     = cnt_arr[row_m1];

  always_comb begin
    nxt_state = state;
    nxt_row   = row;
    nxt_col   = col;
    set_dirty = 1'b0;
    tgt_en    = 1'b0;
    tgt_row   = row;
    tgt_col   = col;
    tgt_code  = i_code;
    tgt_cnt   = col + 4'd1;
    case (state)
      S_IDLE: if (accept) begin
        if (i_code == CODE_CLR) begin
          nxt_state = S_CLEAR;
          nxt_row   = 2'd0;
          nxt_col   = 4'd0;
          set_dirty = 1'b1;
        end else if (i_code == CODE_NL) begin
          set_dirty = 1'b1;
          nxt_col   = 4'd0;
          if (row < LAST_ROW) nxt_row = row + 2'd1;
          else                nxt_state = S_SCROLL;
        end else if (i_code == CODE_BS) begin
          if (col != 4'd0) begin
            set_dirty = 1'b1;
            tgt_en    = 1'b1;
            tgt_col   = col_m1;
            tgt_code  = CODE_BLANK;
            tgt_cnt   = col_m1;
            nxt_col   = col_m1;
          end else if (row != 2'd0) begin
            // Step back to the end of the previous row's text, eating its last letter.
            set_dirty = 1'b1;
            nxt_row   = row_m1;
            nxt_col   = 4'd0;
            if (prev_cnt != 4'd0) begin
              tgt_en   = 1'b1;
              tgt_row  = row_m1;
              tgt_col  = prev_cnt - 4'd1;
              tgt_code = CODE_BLANK;
              tgt_cnt  = prev_cnt - 4'd1;
              nxt_col  = prev_cnt - 4'd1;
            end
          end
        end else begin
          set_dirty = 1'b1;
          tgt_en    = 1'b1;
          if (col == LAST_COL) begin
            nxt_col = 4'd0;
            if (row < LAST_ROW) nxt_row = row + 2'd1;
            else                nxt_state = S_SCROLL;
          end else begin
            nxt_col = col + 4'd1;
          end
        end
      end
      S_SCROLL: if (step == LAST_STEP) begin
        nxt_state = S_IDLE;
        nxt_row   = LAST_ROW;
        nxt_col   = 4'd0;
      end
      S_CLEAR: if (step == LAST_STEP) nxt_state = S_IDLE;
      default: nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= S_IDLE;
      step    <= '0;
      row     <= 2'd0;
      col     <= 4'd0;
      o_dirty <= 1'b0;
    end else begin
      state   <= nxt_state;
      step    <= (state == S_IDLE) ? '0 : step + SW'(1);
      row     <= nxt_row;
      col     <= nxt_col;
      o_dirty <= (o_dirty & ~commit) | set_dirty;
    end
  end

  // Shadow only moves on a commit, so the display sees whole frames of text.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_letters    <= {(ROW_CNT*ROW_SIZE){CODE_BLANK}};
      o_letter_cnt <= '0;
    end else if (commit) begin
      o_letters    <= work;
      o_letter_cnt <= cnt_arr;
    end
  end

  for (genvar r = 0; r < ROW_CNT; r++) begin : g_row
    logic [ROW_SIZE-1:0][7:0] src_cells;
    logic [3:0]               src_cnt;
    logic                     wr, ld, blk;

    if (r < ROW_CNT-1) begin : g_src
      assign src_cells = work[r+1];
      assign src_cnt   = cnt_arr[r+1];
    end else begin : g_last
      assign src_cells = '0;
      assign src_cnt   = 4'd0;
    end

    assign wr  = tgt_en && (tgt_row == 2'(r));
    assign ld  = (state == S_SCROLL) && (step == SW'(r)) && (r < ROW_CNT-1);
    assign blk = ((state == S_CLEAR) && (step == SW'(r))) ||
                 ((state == S_SCROLL) && (step == LAST_STEP) && (r == ROW_CNT-1));

    text_buffer_row #(.ROW_SIZE(ROW_SIZE), .CODE_BLANK(CODE_BLANK)) u_row (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_wr         (wr),
      .i_col        (tgt_col),
      .i_code       (tgt_code),
      .i_cnt        (tgt_cnt),
      .i_load       (ld),
      .i_load_cells (src_cells),
      .i_load_cnt   (src_cnt),
      .i_blank      (blk),
      .o_cells      (work[r]),
      .o_cnt        (cnt_arr[r])
    );
  end
endmodule

// File: tb/tb_text_buffer_ctrl.sv
// Directed bench for text_buffer_ctrl: expectations queued on a scoreboard, popped at check points.

module tb_text_buffer_ctrl;
  localparam int RC = 3;
  localparam int RS = 10;

  logic                        i_clk = 1'b0;
  logic                        i_rst = 1'b1;
  logic                        i_valid = 1'b0;
  logic [7:0]                  i_code = 8'd0;
  logic                        i_frame_start = 1'b0;
  logic                        o_ready;
  logic [RC-1:0][3:0]          o_letter_cnt;
  logic [RC-1:0][RS-1:0][7:0]  o_letters;
  logic [1:0]                  o_cursor_row;
  logic [3:0]                  o_cursor_col;
  logic                        o_dirty;

  text_buffer_ctrl dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_code        (i_code),
    .i_frame_start (i_frame_start),
    .o_letter_cnt  (o_letter_cnt),
    .o_letters     (o_letters),
    .o_cursor_row  (o_cursor_row),
    .o_cursor_col  (o_cursor_col),
    .o_dirty       (o_dirty)
  );

  always #20 i_clk = ~i_clk;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic expect_val(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [63:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%0h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic ck(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    expect_val(tag, exp);
    check(obs);
  endtask

  task automatic do_reset();
    i_valid = 1'b0;
    i_frame_start = 1'b0;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(posedge i_clk); #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (o_ready !== 1'b1 && n < 100) begin
      @(posedge i_clk); #1;
      n++;
    end
    if (o_ready !== 1'b1) begin
      checks++;
      failures++;
      $error("FAIL ready_timeout observed=%0b expected=1", o_ready);
    end
  endtask

  task automatic send(input logic [7:0] c);
    int n;
    wait_ready(n);
    i_valid = 1'b1;
    i_code  = c;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic frame();
    i_frame_start = 1'b1;
    @(posedge i_clk); #1;
    i_frame_start = 1'b0;
  endtask

  initial begin
    int n;
    logic stall;

    // Reset state
    do_reset();
    ck("rst_ready", o_ready, 1);
    ck("rst_row",   o_cursor_row, 0);
    ck("rst_col",   o_cursor_col, 0);
    ck("rst_dirty", o_dirty, 0);
    ck("rst_cnt_zero",  (o_letter_cnt == '0), 1);
    ck("rst_cells_zero", (o_letters == '0), 1);

    // Two letters then a commit
    send(8'd8);
    send(8'd9);
    expect_val("hi_pre_commit_cnt", 0);
    check(o_letter_cnt[0]);
    ck("hi_dirty_pre", o_dirty, 1);
    expect_val("hi_cnt0", 2);
    expect_val("hi_cell00", 8);
    expect_val("hi_cell01", 9);
    frame();
    check(o_letter_cnt[0]);
    check(o_letters[0][0]);
    check(o_letters[0][1]);
    ck("hi_row", o_cursor_row, 0);
    ck("hi_col", o_cursor_col, 2);
    ck("hi_dirty", o_dirty, 0);

    // Ten letters wrap without a stall
    do_reset();
    stall = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (o_ready !== 1'b1) stall = 1'b1;
      send(8'(i));
    end
    ck("wrap_nostall", stall, 0);
    ck("wrap_ready", o_ready, 1);
    ck("wrap_row", o_cursor_row, 1);
    ck("wrap_col", o_cursor_col, 0);
    frame();
    ck("wrap_cnt0", o_letter_cnt[0], 10);
    ck("wrap_cnt1", o_letter_cnt[1], 0);
    ck("wrap_cell09", o_letters[0][9], 10);

    // Thirty letters force a scroll
    do_reset();
    for (int i = 1; i <= 30; i++) send(8'(i));
    n = 0;
    while (o_ready !== 1'b1 && n < 20) begin
      n++;
      @(posedge i_clk); #1;
    end
    ck("scroll_busy_cycles", n, 3);
    ck("scroll_row", o_cursor_row, 2);
    ck("scroll_col", o_cursor_col, 0);
    frame();
    ck("scroll_cnt0", o_letter_cnt[0], 10);
    ck("scroll_cnt1", o_letter_cnt[1], 10);
    ck("scroll_cnt2", o_letter_cnt[2], 0);
    ck("scroll_c00", o_letters[0][0], 11);
    ck("scroll_c09", o_letters[0][9], 20);
    ck("scroll_c10", o_letters[1][0], 21);
    ck("scroll_c19", o_letters[1][9], 30);
    ck("scroll_row2_blank", (o_letters[2] == '0), 1);

    // NL then backspaces across the row boundary
    do_reset();
    send(8'd65);
    send(8'd66);
    send(8'd253);
    ck("nl_row", o_cursor_row, 1);
    ck("nl_col", o_cursor_col, 0);
    send(8'd254);
    ck("bs1_row", o_cursor_row, 0);
    ck("bs1_col", o_cursor_col, 1);
    frame();
    ck("bs1_cnt0", o_letter_cnt[0], 1);
    ck("bs1_c00", o_letters[0][0], 65);
    ck("bs1_c01", o_letters[0][1], 0);
    send(8'd254);
    ck("bs2_col", o_cursor_col, 0);
    frame();
    ck("bs2_cnt0", o_letter_cnt[0], 0);
    ck("bs2_dirty", o_dirty, 0);
    send(8'd254);
    ck("bs3_ready", o_ready, 1);
    ck("bs3_row", o_cursor_row, 0);
    ck("bs3_col", o_cursor_col, 0);
    ck("bs3_dirty", o_dirty, 0);

    // Clear with a frame pulse landing inside the clear sequence
    do_reset();
    send(8'd5);
    send(8'd6);
    frame();
    send(8'd255);
    ck("clr_busy", o_ready, 0);
    frame();
    ck("clr_hold_cnt0", o_letter_cnt[0], 2);
    ck("clr_hold_c00", o_letters[0][0], 5);
    wait_ready(n);
    ck("clr_dirty", o_dirty, 1);
    ck("clr_col", o_cursor_col, 0);
    frame();
    ck("clr_cnt_zero", (o_letter_cnt == '0), 1);
    ck("clr_cells_zero", (o_letters == '0), 1);
    ck("clr_dirty_after", o_dirty, 0);

    // Reset on the second cycle of a scroll
    do_reset();
    for (int i = 1; i <= 9; i++) send(8'(i));
    frame();
    for (int i = 10; i <= 30; i++) send(8'(i));
    @(posedge i_clk); #1;
    ck("mid_scroll_busy", o_ready, 0);
    i_rst = 1'b1;
    #1;
    ck("mid_rst_ready", o_ready, 1);
    ck("mid_rst_row", o_cursor_row, 0);
    ck("mid_rst_col", o_cursor_col, 0);
    ck("mid_rst_dirty", o_dirty, 0);
    ck("mid_rst_cnt_zero", (o_letter_cnt == '0), 1);
    ck("mid_rst_cells_zero", (o_letters == '0), 1);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    ck("post_rst_ready", o_ready, 1);
    ck("post_rst_row", o_cursor_row, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/text_buffer_ctrl.md
# text_buffer_ctrl

Text-buffer controller that sits between the gesture/letter decoder and the VGA display path. It accepts one character code or command per handshake and maintains a ROW_CNT x ROW_SIZE working text array with a cursor. It performs wrap, newline, backspace, multi-cycle scroll and clear. It publishes a tear-free shadow copy (per-row letter counts plus letter codes) to the display only at frame boundaries.

## Interface
- ROW_CNT, 3, number of text rows
- ROW_SIZE, 10, letters per row (max 15; count fields are 4 bits)
- CODE_BLANK, 8'd0, code written into empty cells
- CODE_NL, 8'd253, newline command
- CODE_BS, 8'd254, backspace command
- CODE_CLR, 8'd255, clear-screen command
- i_clk  in  1  pixel clock (25 MHz); one clock domain
- i_rst  in  1  asynchronous, active-high reset
- i_valid  in  1  i_code valid
- o_ready  out  1  block can accept i_code this cycle
- i_code  in  8  letter code or command
- i_frame_start  in  1  one-cycle pulse at start of vertical blank
- o_letter_cnt  out  4 x [0:ROW_CNT-1]  shadow per-row letter count
- o_letters  out  8 x [0:ROW_CNT-1][0:ROW_SIZE-1]  shadow letter codes
- o_cursor_row  out  2  working cursor row
- o_cursor_col  out  4  working cursor column
- o_dirty  out  1  working array differs from the last committed shadow

## Operation
- FSM states: S_IDLE, S_SCROLL, S_CLEAR. o_ready = (state == S_IDLE).
- Accept = i_valid & o_ready. Any code other than NL/BS/CLR is a letter.
- Letter: write work[row][col] = code; cnt[row] = col+1; col++.
  - If col reaches ROW_SIZE and row < ROW_CNT-1: row++, col = 0 in the same update.
  - If col reaches ROW_SIZE and row == ROW_CNT-1: enter S_SCROLL.
- NL: if row < ROW_CNT-1, then row++ and col = 0. Otherwise enter S_SCROLL. Row contents are untouched.
- BS:
  - If col > 0: work[row][col-1] = BLANK, cnt[row] = col-1, col--.
  - Else if row > 0: row--. If cnt[row-1] > 0, blank its last cell, decrement its count, and set col = new count. If cnt[row-1] == 0, col = 0.
  - Else (row 0, col 0): no-op, but the code is still consumed.
- CLR: enter S_CLEAR; cursor goes to (0,0) on entry.
- S_SCROLL: runs ROW_CNT cycles, k = 0..ROW_CNT-1.
  - For k < ROW_CNT-1: row k <= row k+1 (cells and count).
  - For k = ROW_CNT-1: last row is filled with BLANK and its count set to 0.
  - On exit, cursor = (ROW_CNT-1, 0) and state returns to S_IDLE.
- S_CLEAR: runs ROW_CNT cycles; cycle k blanks row k and sets cnt[k] = 0. Then returns to S_IDLE.
- Step counter: a cycle counter of ROW_CNT-range width sequences S_SCROLL and S_CLEAR. It is zeroed on entry to either state.
- Commit: on i_frame_start in S_IDLE with o_dirty = 1, copy the whole working array and counts into the shadow in one cycle, then clear o_dirty.
  - If i_frame_start arrives in S_SCROLL or S_CLEAR, it is ignored. The commit waits for the next frame pulse, so the display never sees a partial scroll or clear.
- Any accepted command, and every scroll or clear, sets o_dirty. A BS no-op does not set it.

## Timing
- Reset values:
  - All working and shadow cells = CODE_BLANK; all counts = 0.
  - Cursor (0,0); o_dirty = 0; state S_IDLE, so o_ready = 1.
- Letter, NL and BS update the working array and cursor on the clock edge of acceptance.
- The shadow outputs change only on a commit edge. o_letters/o_letter_cnt are registered and are stable for a whole frame.
- Scroll or clear: o_ready is low for exactly ROW_CNT cycles, starting the cycle after the triggering accept. It is high again on cycle ROW_CNT+1.
- Simultaneous accept and commit in the same cycle:
  - The shadow captures the pre-accept contents.
  - The accept is applied to the working array.
  - o_dirty stays 1.
- Reset asserted mid-scroll or mid-clear returns immediately to the reset values; no partial state survives.
- The cursor never reads (ROW_CNT-1, ROW_SIZE); a full last row always resolves through scroll.

## Test plan
- Reset, then send 'H'(8), 'I'(9), one i_frame_start -> o_letter_cnt[0] = 2, o_letters[0][0:1] = 8,9, cursor (0,2), o_dirty = 0.
- Send 10 letters 1..10 -> cursor wraps to (1,0) with no stall, o_ready stays 1, cnt[0] = 10.
- Fill 30 letters (codes 1..30) -> o_ready low 3 cycles, then at the next commit row0 = 11..20, row1 = 21..30, row2 blank, cnt = {10,10,0}, cursor (2,0).
- Text "AB" on row 0, NL, then BS twice -> after first BS cursor (0,1), cnt[0] = 1, cell [0][1] = 0. After second BS cursor (0,0), cnt[0] = 0. A third BS is consumed with no state change and o_dirty unchanged.
- CLR issued with i_frame_start pulsed during S_CLEAR -> the shadow keeps the old text for that frame. At the next pulse all counts = 0 and all cells = 0.
- Assert i_rst on the 2nd cycle of a scroll -> all outputs return to reset values, o_ready = 1 the cycle after reset release.
